// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction memory controller.
//   Loads a program from a host into a single-port synchronous SRAM, then
//   streams it back out in address order as a fetch run.
//
// Ports
//   clk, rst_n                  clock; asynchronous active-low reset
//   load_valid/ready/data/last  host write stream (one word per handshake)
//   start                       begin a fetch run of the loaded program
//   stall                       suppress read issue this cycle
//   halt                        abort the fetch run early
//   sram_addr/cen/gwen/wdata    registered SRAM controls (cen, gwen active-low)
//   sram_rdata                  SRAM read data, valid the cycle after a read
//   inst/inst_valid/inst_pc     fetched instruction stream, no backpressure
//   busy                        controller is not idle
//   done                        one-cycle pulse at the end of a fetch run
module imem_ctrl #(
  parameter int INST_WORD = 32,
  parameter int DATA_W    = 32,
  localparam int AW       = $clog2(INST_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              start,
  input  logic              stall,
  input  logic              halt,
  output logic [AW-1:0]     sram_addr,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic [AW-1:0]     inst_pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(INST_WORD - 1);
  localparam logic [AW:0]   ONE       = (AW+1)'(1);

  state_t              state, state_d;
  logic [AW:0]         len, len_d;
  logic [AW-1:0]       wptr, wptr_d;
  logic [AW-1:0]       pc, pc_d;
  logic                cen_d, gwen_d;
  logic [AW-1:0]       addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                done_d;
  logic                vld_p0, vld_p0_d;
  logic                vld_p1;
  logic [AW-1:0]       pc_p1;
  logic                load_hs;
  logic [AW-1:0]       waddr;
  logic [AW:0]         waddr_inc;
  logic [AW:0]         pc_inc;

  assign load_ready = (state == IDLE) || (state == LOAD);
  assign load_hs    = load_valid & load_ready;
  assign busy       = (state != IDLE);
  // A handshake from IDLE always begins a fresh program at address 0.
  assign waddr      = (state == IDLE) ? '0 : wptr;
  assign waddr_inc  = {1'b0, waddr} + ONE;
  assign pc_inc     = {1'b0, pc} + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    len_d    = len;
    wptr_d   = wptr;
    pc_d     = pc;
    cen_d    = 1'b1;
    gwen_d   = 1'b1;
    addr_d   = sram_addr;
    wdata_d  = sram_wdata;
    vld_p0_d = 1'b0;
    done_d   = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (load_hs) begin
          cen_d   = 1'b0;
          gwen_d  = 1'b0;
          addr_d  = waddr;
          wdata_d = load_data;
          // The final slot closes the load so the write pointer never wraps.
          if (load_last || (waddr == LAST_ADDR)) begin
            len_d   = waddr_inc;
            wptr_d  = '0;
            state_d = IDLE;
          end else begin
            len_d   = '0;
            wptr_d  = waddr_inc[AW-1:0];
            state_d = LOAD;
          end
        end else if ((state == IDLE) && start && (len != '0)) begin
          pc_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DRAIN;
        end else if (!stall) begin
          cen_d    = 1'b0;
          addr_d   = pc;
          vld_p0_d = 1'b1;
          pc_d     = pc_inc[AW-1:0];
          if (pc_inc == len) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!vld_p0 && !vld_p1) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= '0;
      wptr       <= '0;
      pc         <= '0;
      sram_cen   <= 1'b1;
      sram_gwen  <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
      done       <= 1'b0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      len        <= len_d;
      wptr       <= wptr_d;
      pc         <= pc_d;
      done       <= done_d;
      // p0: read cycle presented to the SRAM
      sram_cen   <= cen_d;
      sram_gwen  <= gwen_d;
      sram_addr  <= addr_d;
      sram_wdata <= wdata_d;
      vld_p0     <= vld_p0_d;
      // p1: SRAM data returning
      vld_p1     <= vld_p0;
      // output: capture returned word
      inst_valid <= vld_p1;
      if (vld_p1) begin
        inst    <= sram_rdata;
        inst_pc <= pc_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    pc_p1 <= sram_addr;
  end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter INST_WORD, default 32: instruction SRAM depth in words; AW = $clog2(INST_WORD).
REQ-002 Parameter DATA_W, default 32: instruction word width.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load_valid  input  1  host presents an instruction word to write.
REQ-006 load_ready  output  1  controller accepts a load word this cycle.
REQ-007 load_data  input  DATA_W  instruction word to write.
REQ-008 load_last  input  1  qualifies the final word of a program load.
REQ-009 start  input  1  begin a fetch run of the loaded program.
REQ-010 stall  input  1  suppress read issue this cycle.
REQ-011 halt  input  1  abort the fetch run early.
REQ-012 sram_addr  output  AW  SRAM address, registered.
REQ-013 sram_cen  output  1  SRAM chip enable, active-low, registered.
REQ-014 sram_gwen  output  1  SRAM write enable, active-low (0 = write), registered.
REQ-015 sram_wdata  output  DATA_W  SRAM write data, registered.
REQ-016 sram_rdata  input  DATA_W  SRAM read data, valid the cycle after a read cycle.
REQ-017 inst  output  DATA_W  fetched instruction, registered.
REQ-018 inst_valid  output  1  inst/inst_pc valid this cycle; no backpressure.
REQ-019 inst_pc  output  AW  address of inst.
REQ-020 busy  output  1  high whenever state is not IDLE.
REQ-021 done  output  1  one-cycle pulse at end of a fetch run.

Function
REQ-022 FSM states IDLE, LOAD, RUN, DRAIN; internal program length len (AW+1 bits), write pointer wptr, fetch pointer pc.
REQ-023 load_ready = 1 in IDLE and LOAD, 0 in RUN and DRAIN.
REQ-024 Load handshake (load_valid & load_ready): next cycle sram_cen=0, sram_gwen=0, sram_addr=wptr, sram_wdata=load_data; wptr increments.
REQ-025 A handshake in IDLE starts a new load at address 0, clears len, enters LOAD.
REQ-026 A handshake with load_last=1, or at wptr=INST_WORD-1, sets len=wptr+1 and returns to IDLE; wptr never wraps.
REQ-027 In LOAD, cycles without load_valid keep sram_cen=1 and hold wptr.
REQ-028 start in IDLE with len!=0 and no load handshake that cycle: pc=0, enter RUN; otherwise start is ignored (load wins on simultaneous events).
REQ-029 RUN, stall=0, halt=0: next cycle sram_cen=0, sram_gwen=1, sram_addr=pc; pc increments; after issuing pc=len-1 enter DRAIN.
REQ-030 RUN, stall=1: next cycle sram_cen=1, pc holds; reads are issued in strict address order with no skips or duplicates.
REQ-031 halt=1 in RUN (takes priority over stall): no further issue, enter DRAIN.
REQ-032 Read latency: inst_valid=1 exactly 2 cycles after the cycle sram_cen=0 & sram_gwen=1 is driven, with inst=sram_rdata sampled the cycle after that read cycle and inst_pc=its sram_addr.
REQ-033 DRAIN: remain until all issued reads have produced inst_valid, then pulse done for one cycle and enter IDLE; len is retained so a later start reruns the program.
REQ-034 sram_cen=1 and sram_gwen=1 in every cycle not described in REQ-024 or REQ-029.

Reset
REQ-035 On rst_n low, immediately and regardless of state: state=IDLE, sram_cen=1, sram_gwen=1, sram_addr=0, sram_wdata=0, inst=0, inst_pc=0, inst_valid=0, done=0, len=0, wptr=0, pc=0; in-flight reads are discarded.

Verification (INST_WORD=32)
REQ-036 Load 0xA0,0xA1,0xA2,0xA3, load_last on the 4th -> four write cycles, addr 0..3, cen=0, gwen=0, wdata matching; len=4; back to IDLE.
REQ-037 Then start -> reads at addr 0..3 on consecutive cycles; inst_valid for 4 cycles with inst 0xA0..0xA3, inst_pc 0..3; single done pulse; busy drops.
REQ-038 stall held 2 cycles after addr 1 issued -> addr 2 issued 2 cycles later; inst sequence still 0xA0..0xA3 with no duplicates.
REQ-039 Load 32 words without load_last -> last write at addr 31, len=32, IDLE; next load_valid writes addr 0.
REQ-040 halt after addr 1 issued -> no reads of addr 2..3; inst for pc 0,1 delivered; done pulses; start with len=0, or in the same cycle as load_valid -> ignored.
REQ-041 rst_n low mid-RUN -> outputs take REQ-035 values without waiting for clk; no inst_valid after release.
